// File: rtl/core_run_ctrl_pkg.sv
// Shared types and widths for the run/halt/single-step controller.
package core_run_ctrl_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2
  } run_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer and a
// one-cycle registered pulse on each released-to-pressed transition.
module btn_debounce #(
  parameter int unsigned DBNC_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_ni,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DBNC_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DBNC_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Level is active-low: a 1 -> 0 flip seen one cycle late is a press.
    press_d = prev_q & ~level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_ni};
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step controller: gates the core enable, counts retired
// instructions and records the PC each time the core is halted.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int unsigned DBNC_CYCLES  = 250000,
  parameter int unsigned STEP_TIMEOUT = 64,
  parameter bit          RESET_RUN    = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             btn_run_ni,
  input  logic             btn_step_ni,
  input  logic             insn_vld_i,
  input  logic [PC_W-1:0]  pc_debug_i,
  output logic             core_en_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [PC_W-1:0]  halt_pc_o,
  output logic             step_timeout_o
);

  localparam int unsigned StepW = $clog2(STEP_TIMEOUT + 1);

  logic             run_press, step_press;
  logic             core_en;
  run_state_e       state_q, state_d;
  logic [StepW-1:0] step_cnt_q, step_cnt_d;
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
  logic             step_to_q, step_to_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  btn_debounce #(
    .DBNC_CYCLES(DBNC_CYCLES)
  ) u_dbnc_run (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_ni (btn_run_ni),
    .press_o(run_press)
  );

  btn_debounce #(
    .DBNC_CYCLES(DBNC_CYCLES)
  ) u_dbnc_step (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_ni (btn_step_ni),
    .press_o(step_press)
  );

  assign core_en = (state_q != StHalt);

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    halt_pc_d  = halt_pc_q;
    step_to_d  = step_to_q;
    unique case (state_q)
      StHalt: begin
        if (run_press) begin
          state_d = StRun;
        end else if (step_press) begin
          state_d    = StStep;
          step_cnt_d = '0;
          step_to_d  = 1'b0;
        end
      end
      StRun: begin
        if (run_press) begin
          state_d   = StHalt;
          halt_pc_d = pc_debug_i;
        end
      end
      StStep: begin
        // A retire on the last allowed cycle still counts as a clean step.
        if (insn_vld_i) begin
          state_d   = StHalt;
          halt_pc_d = pc_debug_i;
        end else if (step_cnt_q == StepW'(STEP_TIMEOUT - 1)) begin
          state_d   = StHalt;
          halt_pc_d = pc_debug_i;
          step_to_d = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      default: state_d = StHalt;
    endcase
    retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, (insn_vld_i & core_en)};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RESET_RUN ? StRun : StHalt;
      step_cnt_q    <= '0;
      halt_pc_q     <= '0;
      step_to_q     <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      halt_pc_q     <= halt_pc_d;
      step_to_q     <= step_to_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign core_en_o      = core_en;
  assign state_o        = state_q;
  assign retired_cnt_o  = retired_cnt_q;
  assign halt_pc_o      = halt_pc_q;
  assign step_timeout_o = step_to_q;

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run/halt/single-step controller for the pipelined RISC-V core on the DE10 board top level. It debounces two push-buttons and drives a core enable that the core uses as a global stall. Its FSM holds the core halted, lets it free-run, or advances it by exactly one retired instruction. It also counts retired instructions and captures the PC at each halt for display on HEX/LEDR.

## Interface
- `DBNC_CYCLES`, default 250000: consecutive stable cycles needed to accept a button level change (5 ms at 50 MHz).
- `STEP_TIMEOUT`, default 64: maximum enabled cycles per single step before forced halt.
- `RESET_RUN`, default 0: 1 = enter RUN after reset, 0 = enter HALT.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `btn_run_ni` in 1: raw run/halt key, active-low, asynchronous to `clk_i`.
- `btn_step_ni` in 1: raw single-step key, active-low, asynchronous.
- `insn_vld_i` in 1: core retired one instruction this cycle.
- `pc_debug_i` in 32: core PC of the retiring instruction.
- `core_en_o` out 1: 1 = core advances, 0 = core stalled.
- `state_o` out 2: FSM state, HALT=0, RUN=1, STEP=2.
- `retired_cnt_o` out 32: retired instructions since reset.
- `halt_pc_o` out 32: PC captured at the last entry to HALT.
- `step_timeout_o` out 1: sticky flag, last step hit `STEP_TIMEOUT`.

## Operation
- Each key passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level flips only after the synchronized level has differed from it for `DBNC_CYCLES` consecutive cycles.
  - Any glitch back to the current level clears the counter.
  - A one-cycle press pulse is generated on each released→pressed flip. Release produces no pulse.
- FSM:
  - HALT: run pulse → RUN. Step pulse → STEP; entering STEP clears `step_timeout_o` and the step counter. If both pulses arrive together, run wins.
  - RUN: run pulse → HALT. Step pulses are ignored.
  - STEP:
    - `insn_vld_i`=1 → HALT.
    - Otherwise, when the step counter reaches `STEP_TIMEOUT`-1 → HALT and set `step_timeout_o`.
    - If `insn_vld_i` and the timeout coincide, retire wins and `step_timeout_o` stays 0.
    - Run and step pulses are ignored.
- `core_en_o` = 1 in RUN or STEP, decoded from the registered state (no combinational path from inputs).
- `retired_cnt_o` increments when `insn_vld_i` && `core_en_o`. It wraps 0xFFFF_FFFF → 0.
- `halt_pc_o` loads `pc_debug_i` on the edge that moves the FSM into HALT: the retiring PC for a step, the current PC for RUN→HALT and for timeout.
- Reset values:
  - State is HALT, or RUN if `RESET_RUN`=1.
  - `core_en_o` = `RESET_RUN`.
  - `retired_cnt_o`, `halt_pc_o`, `step_timeout_o`, and all debounce counters = 0.
  - Debounced levels and synchronizers = released (1).
- Reset mid-step or mid-debounce drops all progress. No pulse may be emitted on the cycle after reset deasserts, even if a key is held.

## Timing
- Press pulse: high for exactly 1 cycle, `DBNC_CYCLES`+2 edges after the edge that first sampled the raw key low.
- Pulse at cycle N → `state_o` and `core_en_o` change at N+1.
- STEP entered at N with retire at cycle M ≥ N+1 → HALT and `core_en_o`=0 at M+1. This guarantees exactly one counted retire per step.
- Timeout: the STEP entered at N ends at N+`STEP_TIMEOUT`.
- `retired_cnt_o` and `halt_pc_o` update one edge after the qualifying cycle.

## Structure
- `core_run_ctrl_pkg` holds:
  - `run_state_e` enum (HALT, RUN, STEP, 2 bits).
  - `PC_W`=32 and `CNT_W`=32 constants.
- `btn_debounce` sub-module holds the synchronizer, debounce counter and press-pulse logic (parameter `DBNC_CYCLES`). It is instantiated twice.

## Test plan
All scenarios use `DBNC_CYCLES`=4, `STEP_TIMEOUT`=8.
- **Reset:** assert `rst_i` 3 cycles with `btn_run_ni`=0 held → `state_o`=0, `core_en_o`=0, all counters 0; first run pulse arrives 6 edges after release.
- **Bounce rejection:** `btn_step_ni` toggles low 3 cycles / high 1 cycle, repeated 5 times → no pulse, `state_o` stays 0. Then hold low 10 cycles → exactly one step pulse.
- **Single step:** HALT, step press, `insn_vld_i` pulsed 3 cycles after entry with `pc_debug_i`=0x0000_0104 → `core_en_o` high 3 cycles then 0, `retired_cnt_o`=1, `halt_pc_o`=0x104, `state_o`=0.
- **Timeout:** step with `insn_vld_i` held 0 → `core_en_o` high exactly 8 cycles, `step_timeout_o`=1. The next step press clears it on STEP entry.
- **Run/halt:** run press, `insn_vld_i`=1 for 20 cycles, run press → `retired_cnt_o`=20. During RUN a step press leaves `state_o`=1.
- **Priority and wrap:**
  - Simultaneous run+step presses from HALT → `state_o`=1.
  - Counter forced to 0xFFFF_FFFF plus one retire → 0.
  - Retire on the timeout cycle → `step_timeout_o`=0.
